// File: rtl/fetch_realign_buffer_if.sv
// -----------------------------------------------------------------------------
// fetch_realign_buffer_if
//
// Bundles the fetch-side and issue-side signals of the fetch realign buffer.
//
//   fetch_word  [31:0]  word-aligned fetched data, little-endian halfwords
//   fetch_valid         fetch_word is valid
//   fetch_ready         buffer accepts fetch_word this cycle
//   redirect            branch/jump/exception redirect, flushes the buffer
//   redirect_pc [31:0]  new PC, halfword aligned
//   inst_ready          downstream consumes the presented instruction
//   inst_valid          a complete instruction is presented
//   inst32      [31:0]  raw instruction (compressed form zero-extended)
//   inst16      [15:0]  head halfword, feeds the decompressor
//   c_ena               presented instruction is compressed
//   inst_pc     [31:0]  PC of the presented instruction
//
// Modports:
//   master : the fetch/issue environment around the buffer
//   slave  : the buffer itself
// -----------------------------------------------------------------------------
interface fetch_realign_buffer_if;
    logic [31:0] fetch_word;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst32;
    logic [15:0] inst16;
    logic        c_ena;
    logic [31:0] inst_pc;

    modport master (
        output fetch_word,
        output fetch_valid,
        output redirect,
        output redirect_pc,
        output inst_ready,
        input  fetch_ready,
        input  inst_valid,
        input  inst32,
        input  inst16,
        input  c_ena,
        input  inst_pc
    );

    modport slave (
        input  fetch_word,
        input  fetch_valid,
        input  redirect,
        input  redirect_pc,
        input  inst_ready,
        output fetch_ready,
        output inst_valid,
        output inst32,
        output inst16,
        output c_ena,
        output inst_pc
    );
endinterface

// File: rtl/fetch_realign_buffer.sv
// -----------------------------------------------------------------------------
// fetch_realign_buffer
//
// Realigns a stream of word-aligned fetch data into whole instructions. With
// compressed-instruction support, a 4-entry halfword FIFO lets 16-bit and
// 32-bit instructions sit at any halfword offset, including 32-bit
// instructions that straddle two fetched words. Without it, the buffer holds
// one word and every instruction is 32-bit.
//
// Build option:
//   RV32C_SUPPORT_EN  defined   -> halfword FIFO, compressed decode, drop_low
//                     undefined -> one-word buffer, c_ena tied low,
//                                  redirect_pc[1] ignored
//
// Parameters:
//   RESET_PC  PC of the first instruction after reset
//
// Ports:
//   CLK   sole clock, all state updates on its rising edge
//   nRST  synchronous active-low reset
//   bus   fetch_realign_buffer_if.slave (fetch input, instruction output,
//         redirect)
//
// fetch_ready never depends on inst_ready: it is computed from registered
// occupancy and the redirect input only.
// -----------------------------------------------------------------------------
module fetch_realign_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic                   CLK,
    input  logic                   nRST,
    fetch_realign_buffer_if.slave  bus
);

    logic        present;   // complete instruction available (inst_valid)
    logic        push;      // fetch word accepted this cycle
    logic        pop;       // presented instruction consumed this cycle
    logic [31:0] pc_reg;
    logic [31:0] pc_next;

`ifdef RV32C_SUPPORT_EN

    localparam int DEPTH = 4;

    logic [15:0] hw_reg  [DEPTH];    // hw_reg[0] is the head halfword
    logic [15:0] hw_next [DEPTH];
    logic [2:0]  count_reg;
    logic [2:0]  count_next;
    logic        drop_low_reg;
    logic        drop_low_next;

    logic        head_compressed;
    logic        room;
    logic [2:0]  pop_n;              // halfwords leaving the head
    logic [2:0]  push_n;             // halfwords entering at the tail
    logic [2:0]  keep;               // old halfwords surviving the pop
    logic [15:0] push_first;         // first halfword appended on a push
    logic        unused_pc_bit;

    // Only the low two bits of the head decide the instruction length.
    assign head_compressed = (count_reg != 3'd0) && (hw_reg[0][1:0] != 2'b11);

    // A push adds at most two halfwords, so two free slots are needed.
    assign room = (count_reg <= 3'd2);

    // A compressed head needs one halfword (always true when count >= 1);
    // a 32-bit head needs both halves, so a straddled instruction waits here.
    assign present = nRST && !bus.redirect && (head_compressed || (count_reg >= 3'd2));

    assign push = nRST && !bus.redirect && room && bus.fetch_valid;
    assign pop  = present && bus.inst_ready;

    assign pop_n  = !pop  ? 3'd0 : (head_compressed ? 3'd1 : 3'd2);
    assign push_n = !push ? 3'd0 : (drop_low_reg    ? 3'd1 : 3'd2);
    assign keep   = count_reg - pop_n;

    // After a redirect to an odd halfword the low half of the first word
    // belongs to the previous path and is skipped.
    assign push_first = drop_low_reg ? bus.fetch_word[31:16] : bus.fetch_word[15:0];

    // Each slot either takes a surviving entry shifted down by pop_n, or one
    // of the halfwords being appended behind the survivors, or clears. Pop
    // and push in the same cycle therefore neither lose nor reorder data.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            localparam logic [2:0] SLOT = 3'(gi);
            logic [1:0] src_idx;
            logic [2:0] push_idx;

            assign src_idx  = 2'(SLOT + pop_n);
            assign push_idx = SLOT - keep;

            assign hw_next[gi] = (SLOT < keep)      ? hw_reg[src_idx] :
                                 (push_idx < push_n) ? ((push_idx == 3'd0) ? push_first
                                                                           : bus.fetch_word[31:16]) :
                                                       16'h0000;
        end
    endgenerate

    // Redirect wins over any push or pop in the same cycle.
    always_comb begin
        count_next    = count_reg - pop_n + push_n;
        drop_low_next = drop_low_reg && !push;
        pc_next       = pc_reg;
        if (pop) begin
            pc_next = pc_reg + (head_compressed ? 32'd2 : 32'd4);
        end
        if (bus.redirect) begin
            count_next    = 3'd0;
            drop_low_next = bus.redirect_pc[1];
            pc_next       = {bus.redirect_pc[31:1], 1'b0};
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count_reg    <= 3'd0;
            drop_low_reg <= 1'b0;
            pc_reg       <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                hw_reg[i] <= 16'h0000;
            end
        end else begin
            count_reg    <= count_next;
            drop_low_reg <= drop_low_next;
            pc_reg       <= pc_next;
            for (int i = 0; i < DEPTH; i++) begin
                hw_reg[i] <= bus.redirect ? 16'h0000 : hw_next[i];
            end
        end
    end

    // redirect_pc is halfword aligned; bit 0 carries no information.
    assign unused_pc_bit = bus.redirect_pc[0];

    assign bus.fetch_ready = !nRST || (room && !bus.redirect);
    assign bus.inst_valid  = present;
    assign bus.c_ena       = nRST && head_compressed;
    assign bus.inst16      = nRST ? hw_reg[0] : 16'h0000;
    assign bus.inst32      = !nRST          ? 32'h0000_0000 :
                             head_compressed ? {16'h0000, hw_reg[0]} :
                                               {hw_reg[1], hw_reg[0]};
    assign bus.inst_pc     = pc_reg;

`else

    logic [31:0] word_reg;
    logic [31:0] word_next;
    logic        full_reg;
    logic        full_next;
    logic [1:0]  unused_pc_bits;

    assign present = nRST && !bus.redirect && full_reg;

    // With a single word of storage a new word is taken only when empty;
    // refilling on the cycle of a pop would need inst_ready combinationally.
    assign push = nRST && !bus.redirect && !full_reg && bus.fetch_valid;
    assign pop  = present && bus.inst_ready;

    always_comb begin
        full_next = push || (full_reg && !pop);
        word_next = word_reg;
        pc_next   = pc_reg;
        if (push) begin
            word_next = bus.fetch_word;
        end else if (pop) begin
            word_next = 32'h0000_0000;
        end
        if (pop) begin
            pc_next = pc_reg + 32'd4;
        end
        if (bus.redirect) begin
            full_next = 1'b0;
            word_next = 32'h0000_0000;
            pc_next   = {bus.redirect_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            full_reg <= 1'b0;
            word_reg <= 32'h0000_0000;
            pc_reg   <= RESET_PC;
        end else begin
            full_reg <= full_next;
            word_reg <= word_next;
            pc_reg   <= pc_next;
        end
    end

    // Every instruction is word aligned here, so the low PC bits are dropped.
    assign unused_pc_bits = bus.redirect_pc[1:0];

    assign bus.fetch_ready = !nRST || (!full_reg && !bus.redirect);
    assign bus.inst_valid  = present;
    assign bus.c_ena       = 1'b0;
    assign bus.inst16      = nRST ? word_reg[15:0] : 16'h0000;
    assign bus.inst32      = nRST ? word_reg : 32'h0000_0000;
    assign bus.inst_pc     = pc_reg;

`endif

endmodule

// File: tb/tb_fetch_realign_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_realign_buffer
//
// Drives the realign buffer through directed scenarios and a randomized run.
// A reference model holds the buffered halfwords in a queue, tracks the PC and
// the drop-low flag, and derives every expected output from the buffer rules.
// Each retired instruction is printed on one line.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_realign_buffer;

    localparam logic [31:0] RESET_PC = 32'h0000_0200;

`ifdef RV32C_SUPPORT_EN
    localparam int CAP = 2;      // max occupancy (halfwords) that still accepts
`else
    localparam int CAP = 0;
`endif

    logic clk = 1'b0;
    logic nrst;

    always #5 clk = ~clk;

    fetch_realign_buffer_if bus();

    fetch_realign_buffer #(.RESET_PC(RESET_PC)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        c;
    } ret_t;

    int          n_vectors     = 0;
    int          n_miscompares = 0;
    logic [15:0] m_q[$];         // model: buffered halfwords, head first
    logic [31:0] m_pc;
    logic        m_drop;
    ret_t        obs_q[$];       // instructions the DUT handed over

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Halfwords needed by the instruction at the head of the model queue.
    function automatic int head_len();
`ifdef RV32C_SUPPORT_EN
        if (m_q.size() >= 1 && m_q[0][1:0] != 2'b11) return 1;
`endif
        return 2;
    endfunction

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input logic rst_n, input logic fv, input logic [31:0] fw,
                        input logic rd, input logic [31:0] rpc, input logic ir,
                        output logic acc);
        int          need;
        logic        exp_v;
        logic        exp_c;
        logic        exp_fr;
        logic [31:0] exp_i32;
        @(negedge clk);
        nrst            = rst_n;
        bus.fetch_valid = fv;
        bus.fetch_word  = fw;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.inst_ready  = ir;
        #1;
        need    = head_len();
        exp_c   = rst_n && (m_q.size() >= 1) && (need == 1);
        exp_v   = rst_n && !rd && (m_q.size() >= need);
        exp_fr  = !rst_n || (!rd && (m_q.size() <= CAP));
        exp_i32 = 32'h0;
        if (exp_v) exp_i32 = (need == 1) ? {16'h0, m_q[0]} : {m_q[1], m_q[0]};

        check_value("fetch_ready", bus.fetch_ready, exp_fr);
        check_value("inst_valid", bus.inst_valid, exp_v);
        check_value("c_ena", bus.c_ena, exp_c);
        check_value("inst_pc", bus.inst_pc, m_pc);
        if (exp_v || !rst_n) check_value("inst32", bus.inst32, exp_i32);
        if (!rst_n) check_value("inst16_rst", bus.inst16, 32'h0);
        else if (m_q.size() >= 1) check_value("inst16", bus.inst16, m_q[0]);

        if (rst_n && bus.inst_valid && bus.inst_ready) begin
            obs_q.push_back({bus.inst_pc, bus.inst32, bus.c_ena});
            $display("retire pc=%08h inst=%08h c=%0d", bus.inst_pc, bus.inst32, bus.c_ena);
        end
        acc = rst_n && fv && bus.fetch_ready;

        if (!rst_n) begin
            m_q.delete();
            m_pc   = RESET_PC;
            m_drop = 1'b0;
        end else if (rd) begin
            m_q.delete();
`ifdef RV32C_SUPPORT_EN
            m_pc   = {rpc[31:1], 1'b0};
            m_drop = rpc[1];
`else
            m_pc   = {rpc[31:2], 2'b00};
            m_drop = 1'b0;
`endif
        end else begin
            if (exp_v && ir) begin
                for (int k = 0; k < need; k++) void'(m_q.pop_front());
                m_pc = m_pc + 32'(need * 2);
            end
            if (fv && exp_fr) begin
                if (m_drop) begin
                    m_q.push_back(fw[31:16]);
                    m_drop = 1'b0;
                end else begin
                    m_q.push_back(fw[15:0]);
                    m_q.push_back(fw[31:16]);
                end
            end
        end
    endtask

    task automatic idle(input logic ir, input int n);
        logic acc;
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, ir, acc);
    endtask

    task automatic do_reset();
        logic acc;
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, acc);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, acc);
        obs_q.delete();
    endtask

    // Offer a word until the DUT takes it, with a bounded number of tries.
    task automatic push_word(input logic [31:0] w, input logic ir);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 16) begin
            step(1'b1, 1'b1, w, 1'b0, 32'h0, ir, acc);
            tries++;
        end
        check_value("push_accepted", {31'h0, acc}, 32'h1);
    endtask

    task automatic check_ret(input string tag, input int idx, input logic [31:0] pc,
                             input logic [31:0] inst, input logic c);
        if (idx < obs_q.size()) begin
            check_value({tag, "_pc"}, obs_q[idx].pc, pc);
            check_value({tag, "_inst"}, obs_q[idx].inst, inst);
            check_value({tag, "_c"}, obs_q[idx].c, c);
        end else begin
            check_value({tag, "_count"}, obs_q.size(), idx + 1);
        end
    endtask

    initial begin
        logic        acc;
        logic [31:0] words [3];
        int          idx;

        nrst            = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.fetch_word  = 32'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready  = 1'b0;
        repeat (2) @(posedge clk);
        m_q.delete();
        m_pc   = RESET_PC;
        m_drop = 1'b0;

        // Two back-to-back 32-bit instructions.
        do_reset();
        push_word(32'h00A00093, 1'b1);
        push_word(32'h00100113, 1'b1);
        idle(1'b1, 4);
        check_ret("two32_a", 0, 32'h200, 32'h00A00093, 1'b0);
        check_ret("two32_b", 1, 32'h204, 32'h00100113, 1'b0);

        // Two compressed instructions in one word.
        do_reset();
        push_word(32'h45014581, 1'b1);
        idle(1'b1, 3);
`ifdef RV32C_SUPPORT_EN
        check_ret("pair16_a", 0, 32'h200, 32'h00004581, 1'b1);
        check_ret("pair16_b", 1, 32'h202, 32'h00004501, 1'b1);
`else
        check_ret("pair16_a", 0, 32'h200, 32'h45014581, 1'b0);
`endif

        // Compressed then a 32-bit instruction straddling two words.
        do_reset();
        push_word(32'h00934581, 1'b1);
        idle(1'b1, 3);
`ifdef RV32C_SUPPORT_EN
        check_value("straddle_held_valid", bus.inst_valid, 32'h0);
        check_value("straddle_held_pc", bus.inst_pc, 32'h202);
        check_value("straddle_held_count", obs_q.size(), 32'd1);
`endif
        push_word(32'h00000000, 1'b1);
        idle(1'b1, 3);
`ifdef RV32C_SUPPORT_EN
        check_ret("straddle_a", 0, 32'h200, 32'h00004581, 1'b1);
        check_ret("straddle_b", 1, 32'h202, 32'h00000093, 1'b0);
`else
        check_ret("straddle_a", 0, 32'h200, 32'h00934581, 1'b0);
        check_ret("straddle_b", 1, 32'h204, 32'h00000000, 1'b0);
`endif

        // Redirect to an odd halfword; the word offered with it is discarded.
        do_reset();
        step(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 32'h00001002, 1'b1, acc);
        push_word(32'h45051234, 1'b1);
        idle(1'b1, 3);
`ifdef RV32C_SUPPORT_EN
        check_ret("redir_odd", 0, 32'h1002, 32'h00004505, 1'b1);
`else
        check_ret("redir_odd", 0, 32'h1000, 32'h45051234, 1'b0);
`endif

        // Downstream stalls for 5 cycles while fetch keeps offering words.
        do_reset();
        words[0] = 32'h00A00093;
        words[1] = 32'h00100113;
        words[2] = 32'h00200193;
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, words[idx], 1'b0, 32'h0, 1'b0, acc);
            if (acc) idx++;
        end
        check_value("stall_fetch_ready", bus.fetch_ready, 32'h0);
        check_value("stall_inst_valid", bus.inst_valid, 32'h1);
        for (int k = 0; k < 12; k++) begin
            step(1'b1, idx < 3, (idx < 3) ? words[idx] : 32'h0, 1'b0, 32'h0, 1'b1, acc);
            if (acc) idx++;
        end
        check_ret("stall_a", 0, 32'h200, 32'h00A00093, 1'b0);
        check_ret("stall_b", 1, 32'h204, 32'h00100113, 1'b0);
        check_ret("stall_c", 2, 32'h208, 32'h00200193, 1'b0);

        // Reset in the middle of a straddle, together with a redirect.
        do_reset();
        push_word(32'h00934581, 1'b1);
        idle(1'b1, 2);
        step(1'b0, 1'b1, 32'h11111111, 1'b1, 32'h00003000, 1'b1, acc);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, acc);
        check_value("rst_mid_valid", bus.inst_valid, 32'h0);
        check_value("rst_mid_pc", bus.inst_pc, RESET_PC);
        check_value("rst_mid_ready", bus.fetch_ready, 32'h1);

        // Randomized traffic, including redirects near the top of memory.
        do_reset();
        for (int cyc = 0; cyc < 2500; cyc++) begin
            logic        r_n;
            logic        fv;
            logic        rd;
            logic        ir;
            logic [31:0] fw;
            logic [31:0] rpc;
            r_n = ($urandom_range(0, 127) != 0);
            fv  = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 23) == 0);
            ir  = ($urandom_range(0, 9) < 7);
            fw  = $urandom;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8 | ($urandom & 32'h6);
            else                           rpc = $urandom & 32'hFFFF_FFFE;
            step(r_n, fv, fw, rd, rpc, ir, acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
